// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern-detector path.
package serial_pkg;

    // Serializer control states.
    typedef enum logic [0:0] {
        StIdle,
        StShift
    } feeder_state_e;

    // Default byte width for the serial path.
    localparam int unsigned DefaultDataW = 8;

    // Line level while nothing is shifting; the detector relies on idle-high.
    localparam logic IdleLvl = 1'b1;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Byte handshake between a source and the serial bit feeder.
interface serial_bit_feeder_if
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Small circular-buffer FIFO with combinational head read and async reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LvlW'(DEPTH));
    assign empty    = (level_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];
    assign level    = level_q;

    // Storage write; entries are only read once counted in level, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: buffers bytes and shifts them out gaplessly
// with a programmable bit period.
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LVL   = IdleLvl
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            div,
    serial_bit_feeder_if.slave          in_bus,
    output logic                        dout,
    output logic                        bit_strobe,
    output logic                        byte_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

    feeder_state_e     state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] head;
    logic [CntW-1:0]   bit_cnt_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [DIV_W-1:0]  period_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              byte_end;
    logic              busy_d;

    // Bit that goes on the line first for a freshly loaded word.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (in_bus.in_data),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Handshake, pop decision and lookahead for the registered busy flag.
    always_comb begin
        in_bus.in_ready = !fifo_full && !rst;
        push            = in_bus.in_valid && in_bus.in_ready;
        byte_end        = (state_q == StShift) && (div_cnt_q == '0) && (bit_cnt_q == '0);
        // Loading at the final edge of a byte keeps the stream gapless.
        pop             = !fifo_empty && ((state_q == StIdle) || byte_end);
        shift_next      = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        busy_d          = pop || ((state_q == StShift) && !byte_end) || push ||
                          (fifo_level > {{(LvlW-1){1'b0}}, pop});
    end

    // Serializer FSM with registered line and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            period_q   <= '0;
            dout       <= IDLE_LVL;
            bit_strobe <= 1'b0;
            byte_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy       <= busy_d;
            bit_strobe <= 1'b0;
            byte_done  <= 1'b0;
            if (pop) begin
                // div is sampled only here, so mid-byte changes wait for the next byte.
                state_q    <= StShift;
                shift_q    <= head;
                period_q   <= div;
                div_cnt_q  <= div;
                bit_cnt_q  <= CntW'(DATA_W - 1);
                dout       <= first_bit(head);
                bit_strobe <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        dout <= IDLE_LVL;
                    end
                    StShift: begin
                        if (div_cnt_q != '0) begin
                            div_cnt_q <= div_cnt_q - 1'b1;
                            // Flag the last cycle of the final bit one edge early.
                            byte_done <= (bit_cnt_q == '0) && (div_cnt_q == DIV_W'(1));
                        end else if (bit_cnt_q != '0) begin
                            shift_q    <= shift_next;
                            dout       <= first_bit(shift_next);
                            bit_cnt_q  <= bit_cnt_q - 1'b1;
                            div_cnt_q  <= period_q;
                            bit_strobe <= 1'b1;
                            byte_done  <= (bit_cnt_q == CntW'(1)) && (period_q == '0);
                        end else begin
                            state_q <= StIdle;
                            dout    <= IDLE_LVL;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench: two feeders (MSB-first and LSB-first) share one stimulus
// stream; a byte-level timing model predicts every output cycle.
module tb_serial_bit_feeder;

    typedef struct {
        logic [7:0]  data;
        int unsigned p_edge;  // edge at which the byte was accepted
        int unsigned s_edge;  // edge after which its first bit is on the line
        int unsigned per;     // bit period in cycles minus one
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  div_r = '0;
    logic [7:0]  tb_data = '0;
    logic        tb_valid = 1'b0;

    logic [1:0]  dout_w;
    logic [1:0]  strobe_w;
    logic [1:0]  done_w;
    logic [1:0]  busy_w;
    logic [2:0]  lvl_w [2];

    int unsigned edge_cnt = 0;
    int unsigned last_end = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    rec_t        sb[$];

    serial_bit_feeder_if #(.DATA_W(8)) bus0 ();
    serial_bit_feeder_if #(.DATA_W(8)) bus1 ();

    assign bus0.in_data  = tb_data;
    assign bus0.in_valid = tb_valid;
    assign bus1.in_data  = tb_data;
    assign bus1.in_valid = tb_valid;

    serial_bit_feeder #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (8),
        .MSB_FIRST  (1'b1),
        .IDLE_LVL   (1'b1)
    ) u_msb (
        .clk        (clk),
        .rst        (rst),
        .div        (div_r),
        .in_bus     (bus0),
        .dout       (dout_w[0]),
        .bit_strobe (strobe_w[0]),
        .byte_done  (done_w[0]),
        .busy       (busy_w[0]),
        .fifo_level (lvl_w[0])
    );

    serial_bit_feeder #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (8),
        .MSB_FIRST  (1'b0),
        .IDLE_LVL   (1'b1)
    ) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .div        (div_r),
        .in_bus     (bus1),
        .dout       (dout_w[1]),
        .bit_strobe (strobe_w[1]),
        .byte_done  (done_w[1]),
        .busy       (busy_w[1]),
        .fifo_level (lvl_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d edge %0d: got %0h, expected %0h", nm, d, edge_cnt, act, exp);
        end
    endtask

    // Monitor: predicts each cycle from the queued byte records.
    always @(negedge clk) begin
        int unsigned e;
        int unsigned lvl;
        int unsigned len;
        int unsigned o;
        int unsigned idx;
        logic [7:0]  dat;
        logic        x_dout [2];
        logic        x_strb;
        logic        x_done;
        logic        x_busy;
        e = edge_cnt;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                chk("rst_dout", d, 32'(dout_w[d]), 32'd1);
                chk("rst_strobe", d, 32'(strobe_w[d]), 32'd0);
                chk("rst_done", d, 32'(done_w[d]), 32'd0);
                chk("rst_busy", d, 32'(busy_w[d]), 32'd0);
                chk("rst_level", d, 32'(lvl_w[d]), 32'd0);
            end
            chk("rst_ready", 0, 32'(bus0.in_ready), 32'd0);
        end else begin
            lvl = 0;
            foreach (sb[i]) if (sb[i].p_edge <= e && sb[i].s_edge > e) lvl++;
            x_dout[0] = 1'b1;
            x_dout[1] = 1'b1;
            x_strb    = 1'b0;
            x_done    = 1'b0;
            x_busy    = (sb.size() != 0);
            len       = 0;
            if (sb.size() != 0 && e >= sb[0].s_edge) begin
                len       = 8 * (sb[0].per + 1);
                o         = e - sb[0].s_edge;
                idx       = o / (sb[0].per + 1);
                dat       = sb[0].data;
                x_dout[0] = dat[7 - idx];
                x_dout[1] = dat[idx];
                x_strb    = (o % (sb[0].per + 1)) == 0;
                x_done    = (o == len - 1);
            end
            for (int d = 0; d < 2; d++) begin
                chk("dout", d, 32'(dout_w[d]), 32'(x_dout[d]));
                chk("bit_strobe", d, 32'(strobe_w[d]), 32'(x_strb));
                chk("byte_done", d, 32'(done_w[d]), 32'(x_done));
                chk("busy", d, 32'(busy_w[d]), 32'(x_busy));
                chk("fifo_level", d, 32'(lvl_w[d]), lvl);
            end
            chk("in_ready", 0, 32'(bus0.in_ready), 32'(lvl != 4));
            chk("in_ready", 1, 32'(bus1.in_ready), 32'(lvl != 4));
            if (len != 0 && e == sb[0].s_edge + len - 1) void'(sb.pop_front());
        end
    end

    // Offer a byte until accepted; on acceptance queue its predicted schedule.
    task automatic push_byte(input logic [7:0] b);
        bit          acc = 1'b0;
        bit          rdy;
        int unsigned tries = 0;
        rec_t        r;
        @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = b;
        while (!acc) begin
            #1;
            rdy = bus0.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc      = 1'b1;
                r.data   = b;
                r.p_edge = edge_cnt;
                r.per    = div_r;
                r.s_edge = (edge_cnt + 1 > last_end) ? edge_cnt + 1 : last_end;
                last_end = r.s_edge + 8 * (r.per + 1);
                sb.push_back(r);
            end else begin
                tries++;
                if (tries > 500) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: got in_ready=0 for 500 cycles, expected 1");
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned tgt;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single byte, one bit per clock.
        div_r = 8'd0;
        push_byte(8'h55);
        drop_valid();
        wait_idle();

        // Gapless pair.
        push_byte(8'h05);
        push_byte(8'h55);
        drop_valid();
        wait_idle();

        // Divider, then change div mid-byte: only the following byte sees it.
        div_r = 8'd2;
        push_byte(8'hA0);
        drop_valid();
        tgt = sb[0].s_edge + 2;
        while (edge_cnt < tgt) begin
            @(posedge clk);
            #1;
        end
        div_r = 8'd0;
        push_byte(8'h3C);
        drop_valid();
        wait_idle();

        // FIFO full with in_valid held.
        div_r = 8'd3;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h11 * (i + 1)));
        drop_valid();
        wait_idle();

        // Reset during bit 3 of 0xF0.
        div_r = 8'd1;
        push_byte(8'hF0);
        drop_valid();
        tgt = sb[0].s_edge + 6;
        while (edge_cnt < tgt) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        sb.delete();
        last_end = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_dout", d, 32'(dout_w[d]), 32'd1);
            chk("async_rst_level", d, 32'(lvl_w[d]), 32'd0);
            chk("async_rst_done", d, 32'(done_w[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_byte(8'h96);
        drop_valid();
        wait_idle();

        // Randomized stream; div changes only while drained.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                drop_valid();
                wait_idle();
                div_r = 8'($urandom_range(0, 3));
            end
            push_byte(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                drop_valid();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drop_valid();
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the serial pattern-detector path. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It shifts them out one bit at a time on `dout`, with a programmable bit period. Back-to-back bytes go out with no idle gap, so an 8-bit pattern split across byte boundaries stays contiguous for the downstream detector, which samples `din` on every `clk`.

## Interface
- `DATA_W`, 8, byte width in bits (≥2)
- `FIFO_DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `DIV_W`, 8, width of bit-period divider
- `MSB_FIRST`, 1, 1 = shift MSB first, 0 = LSB first
- `IDLE_LVL`, 1'b1, `dout` level when nothing is shifting
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `div` in DIV_W: bit period minus one, in clk cycles (0 = one bit per clk)
- `in_data` in DATA_W: byte to send
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: FIFO can accept
- `dout` out 1: serial bit, registered; drives detector `din`
- `bit_strobe` out 1: 1-cycle pulse in the first cycle each new bit is on `dout`
- `byte_done` out 1: 1-cycle pulse in the last cycle of each byte's final bit
- `busy` out 1: shifting or FIFO non-empty
- `fifo_level` out $clog2(FIFO_DEPTH)+1: entries held

## Operation
- **Reset values:**
  - `dout` = IDLE_LVL.
  - `bit_strobe`, `byte_done`, `busy` = 0.
  - `fifo_level` = 0.
  - FIFO pointers, shift register, bit counter, divider counter cleared.
  - FSM in IDLE.
  - `in_ready` = 0 while `rst` is high.
- **Handshake:**
  - Push on posedge when `in_valid && in_ready`.
  - `in_ready = (fifo_level != FIFO_DEPTH) && !rst`, combinational from registered count.
  - A same-cycle pop does not raise `in_ready` on a full FIFO.
  - `in_data` is held by the source until accepted.
- **FSM, 2 states:**
  - **IDLE:** `dout` = IDLE_LVL. If FIFO non-empty: pop head, load shift reg, latch `div` into period reg, bit_cnt = DATA_W−1, div_cnt = latched div, drive first bit, assert `bit_strobe`, go to SHIFT.
  - **SHIFT:** hold `dout` while div_cnt ≠ 0, decrementing each cycle. At div_cnt = 0:
    - If bit_cnt ≠ 0: shift, drive next bit, decrement bit_cnt, reload div_cnt, pulse `bit_strobe`.
    - If bit_cnt = 0: pulse `byte_done`. If FIFO non-empty, pop and load the next byte in the same edge (gapless) and stay in SHIFT. Otherwise return to IDLE, so `dout` = IDLE_LVL on the next cycle.
- **Divider sampling:** `div` is sampled only at byte load. Changes mid-byte take effect on the next byte.
- **FIFO:**
  - Circular buffer, pointer wrap at FIFO_DEPTH.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
  - Pop never occurs on empty.
- **Bit order:** MSB_FIRST = 1 sends bit DATA_W−1 first. Otherwise bit 0 first.

## Timing
- **Latency:** byte pushed at edge N into an empty FIFO with FSM in IDLE gives first bit on `dout` after edge N+1, with `bit_strobe` high in that cycle.
- **Bit duration:** each bit is on `dout` for exactly `div+1` cycles.
- **Byte duration:** each byte occupies `DATA_W·(div+1)` cycles.
- **Continuous stream:** with the FIFO kept non-empty, `dout` never returns to IDLE_LVL between bytes.
- **`busy`:** registered. Falls in the cycle `dout` returns to IDLE_LVL.
- **Reset mid-byte:**
  - `dout` goes to IDLE_LVL immediately (async).
  - Partial byte and FIFO contents are discarded.
  - The first push is possible in the first cycle after `rst` deasserts.

## Structure
- Shared package `serial_pkg`:
  - FSM state enum (IDLE, SHIFT).
  - Default `DATA_W`.
  - `IDLE_LVL` constant, shared with the detector, whose idle-on-1 behaviour depends on it.
- One sub-module, `sync_fifo`:
  - Parameters: width, depth.
  - Ports: push, pop, data, full, empty, level.
  - Async reset.
- The top holds the FSM, divider, shift register and bit counter.

## Test plan
- **Single byte:** reset, div=0, push 0x55, MSB_FIRST=1 → `dout` = 0,1,0,1,0,1,0,1 on 8 consecutive cycles starting the cycle after the push edge, then 1. `byte_done` pulses once; `busy` then falls.
- **Gapless pair:** div=0, push 0x05 then 0x55 back-to-back → 16 contiguous bits 0000_0101_0101_0101, with no IDLE_LVL cycle between bytes. A detector attached downstream flags once.
- **Divider:** div=2, push 0xA0 → each bit held 3 cycles, 8 `bit_strobe` pulses spaced 3 apart. Changing `div` to 0 mid-byte has no effect until the next byte.
- **FIFO full:** div=3, push 6 bytes with `in_valid` held → `in_ready` low once `fifo_level` reaches 4 (first byte already popped). All 6 bytes are serialized in order and none are lost.
- **Reset mid-byte:** assert `rst` during bit 3 of 0xF0 → `dout` = 1 in the same cycle, `fifo_level` = 0, no `byte_done`. The next push after release starts a clean byte.
- **LSB_FIRST:** MSB_FIRST=0, push 0x01 → `dout` = 1 followed by seven 0s, then idle 1.
